// File: rtl/switch_allocator_if.sv
// Bundle between the input units, the switch allocator and the crossbar:
// head-of-queue status and back-pressure in, grants and crossbar selects out.
interface switch_allocator_if #(
    parameter int NUM_PORTS = 5,
    parameter int PORT_W    = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0]        i_req;
    logic [NUM_PORTS*PORT_W-1:0] i_dest;
    logic [NUM_PORTS-1:0]        i_tail;
    logic [NUM_PORTS-1:0]        i_out_ready;
    logic [NUM_PORTS-1:0]        o_in_grant;
    logic [NUM_PORTS-1:0]        o_out_valid;
    logic [NUM_PORTS*PORT_W-1:0] o_sel;
    logic [NUM_PORTS-1:0]        o_locked;

    // Input-unit / downstream side drives requests, sees grants.
    modport master (
        output i_req, i_dest, i_tail, i_out_ready,
        input  o_in_grant, o_out_valid, o_sel, o_locked
    );

    // Allocator side.
    modport slave (
        input  i_req, i_dest, i_tail, i_out_ready,
        output o_in_grant, o_out_valid, o_sel, o_locked
    );
endinterface

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: one round-robin arbiter per output, each output
// locked to its winning input until that input's tail flit crosses.
module switch_allocator #(
    parameter int NUM_PORTS = 5,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input logic               clk,
    input logic               reset_n,
    switch_allocator_if.slave bus
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;
    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

    logic [0:0]        state_q [NUM_PORTS];
    logic [0:0]        state_d [NUM_PORTS];
    logic [PORT_W-1:0] owner_q [NUM_PORTS];
    logic [PORT_W-1:0] owner_d [NUM_PORTS];
    logic [PORT_W-1:0] rrPtr_q [NUM_PORTS];
    logic [PORT_W-1:0] rrPtr_d [NUM_PORTS];

    logic [NUM_PORTS-1:0] busy;
    logic [NUM_PORTS-1:0] ownerReq;
    logic [NUM_PORTS-1:0] ownerTail;
    logic [NUM_PORTS-1:0] xfer;
    logic [NUM_PORTS-1:0] inGrant;
    logic [NUM_PORTS-1:0] found;
    logic [PORT_W-1:0]    winner [NUM_PORTS];

    // An input that already owns some output may not compete for another.
    always_comb begin
        busy = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (state_q[j] == LOCKED && owner_q[j] == PORT_W'(i)) begin
                    busy[i] = 1'b1;
                end
            end
        end
    end

    // Look up the owner's request and tail bits; a transfer needs the owner
    // to have a flit and downstream to be on, and never happens in reset.
    always_comb begin
        ownerReq  = '0;
        ownerTail = '0;
        xfer      = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (owner_q[j] == PORT_W'(i)) begin
                    ownerReq[j]  = bus.i_req[i];
                    ownerTail[j] = bus.i_tail[i];
                end
            end
            xfer[j] = reset_n && (state_q[j] == LOCKED) && ownerReq[j]
                      && bus.i_out_ready[j];
        end
    end

    // Route each output's transfer back to the dequeue strobe of its owner.
    always_comb begin
        inGrant = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (xfer[j] && owner_q[j] == PORT_W'(i)) begin
                    inGrant[i] = 1'b1;
                end
            end
        end
    end

    // Round-robin search per output starting at its pointer, wrapping modulo
    // NUM_PORTS; out-of-range destinations never compare equal to any output.
    always_comb begin
        logic [PORT_W:0]   sum;
        logic [PORT_W-1:0] idx;
        sum = '0;
        idx = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            found[j]  = 1'b0;
            winner[j] = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                sum = {1'b0, rrPtr_q[j]} + (PORT_W+1)'(k);
                if (sum >= (PORT_W+1)'(NUM_PORTS)) begin
                    sum = sum - (PORT_W+1)'(NUM_PORTS);
                end
                idx = sum[PORT_W-1:0];
                if (!found[j] && bus.i_req[idx] && !busy[idx]
                    && bus.i_dest[idx*PORT_W +: PORT_W] == PORT_W'(j)) begin
                    found[j]  = 1'b1;
                    winner[j] = idx;
                end
            end
        end
    end

    // Lock on a win; release and advance the pointer past the owner on its tail.
    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            state_d[j] = state_q[j];
            owner_d[j] = owner_q[j];
            rrPtr_d[j] = rrPtr_q[j];
            if (state_q[j] == IDLE) begin
                if (found[j]) begin
                    state_d[j] = LOCKED;
                    owner_d[j] = winner[j];
                end
            end else if (xfer[j] && ownerTail[j]) begin
                state_d[j] = IDLE;
                rrPtr_d[j] = (owner_q[j] == LAST_PORT) ? '0 : owner_q[j] + 1'b1;
            end
        end
    end

    // Per-output state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!reset_n) begin
                state_q[j] <= IDLE;
                owner_q[j] <= '0;
                rrPtr_q[j] <= '0;
            end else begin
                state_q[j] <= state_d[j];
                owner_q[j] <= owner_d[j];
                rrPtr_q[j] <= rrPtr_d[j];
            end
        end
    end

    // Crossbar selects and lock flags come straight from the registered state.
    always_comb begin
        bus.o_sel    = '0;
        bus.o_locked = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            bus.o_locked[j] = (state_q[j] == LOCKED);
            if (state_q[j] == LOCKED) begin
                bus.o_sel[j*PORT_W +: PORT_W] = owner_q[j];
            end
        end
    end

    assign bus.o_in_grant  = inGrant;
    assign bus.o_out_valid = xfer;
endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Wormhole switch allocator for one router. It sits between the input units' head-of-queue status and the crossbar select lines.
- One round-robin arbiter per output port. A granted output stays locked to its winning input until that input's tail flit crosses.
- Each cycle it produces the crossbar selects, the per-input dequeue strobes and the per-output transmit strobes. Downstream on/off back-pressure gates every transfer.

Parameters:
- NUM_PORTS, 5, number of router ports (input count equals output count).
- PORT_W, $clog2(NUM_PORTS) = 3, width of a port index.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- i_req  in  NUM_PORTS  bit i=1: input i holds a valid flit at head of queue.
- i_dest  in  NUM_PORTS*PORT_W  slice i: output index routed for input i's head flit.
- i_tail  in  NUM_PORTS  bit i=1: input i's head flit is a tail (head+tail marks a single-flit packet).
- i_out_ready  in  NUM_PORTS  bit j=1: downstream of output j is "on".
- o_in_grant  out  NUM_PORTS  bit i=1: input i's head flit crosses this cycle; the input unit dequeues it.
- o_out_valid  out  NUM_PORTS  bit j=1: output j receives a flit this cycle.
- o_sel  out  NUM_PORTS*PORT_W  slice j: crossbar select, meaning the input index driving output j.
- o_locked  out  NUM_PORTS  bit j=1: output j is allocated (state LOCKED).

Behaviour:
- Per-output registered state: state_j in {IDLE, LOCKED}; owner_j [PORT_W]; rr_ptr_j [PORT_W].
- Reset (reset_n=0 at posedge): all state_j=IDLE, owner_j=0, rr_ptr_j=0.
- While in reset, and after reset with no requests: o_in_grant=0, o_out_valid=0, o_locked=0, o_sel=0.
- Reset mid-packet drops every lock with no flit transfer. Packet recovery is the input units' concern.
- busy_i = OR over j of (state_j==LOCKED && owner_j==i).
- Candidate set for output j: inputs i with i_req[i]=1, i_dest[i]==j, busy_i=0.
- i_dest values >= NUM_PORTS never match any output. The flit is never granted.
- IDLE, candidate set non-empty:
  - Pick the first candidate searching i = rr_ptr_j, rr_ptr_j+1, ... modulo NUM_PORTS.
  - Next cycle: state_j=LOCKED, owner_j=winner.
  - No transfer occurs in the arbitration cycle (one-cycle allocation latency).
- IDLE, candidate set empty: stay IDLE.
- LOCKED, transfer: xfer_j = i_req[owner_j] && i_out_ready[j] (combinational).
  - o_out_valid[j]=xfer_j.
  - o_in_grant[owner_j]=1 when xfer_j.
  - o_sel slice j = owner_j whenever LOCKED, and 0 when IDLE.
- LOCKED, xfer_j && i_tail[owner_j]:
  - Next cycle: state_j=IDLE.
  - rr_ptr_j = (owner_j+1) mod NUM_PORTS, with explicit wrap so NUM_PORTS-1 wraps to 0.
  - The earliest re-arbitration is the cycle after the tail; the earliest next transfer is two cycles after the tail.
- LOCKED, no transfer: hold state and owner. There is no timeout. A stalled owner or an "off" downstream blocks output j indefinitely.
- rr_ptr_j changes only on tail completion, never on allocation.
- An input owns at most one output at a time, guaranteed by the busy mask. Therefore at most one bit of o_in_grant is driven per input, and no output conflicts exist.
- Distinct outputs arbitrate independently in the same cycle.
- i_dest of an owning input is not re-checked while LOCKED; body flits carry no route.
- Outputs o_in_grant and o_out_valid are combinational from registered state plus i_req/i_out_ready/i_tail, with no combinational path from i_dest. o_sel and o_locked are purely registered.

Test Plan:
- Single packet: input 1, dest 3, 3 flits (tail on 3rd), ready=1.
  - Cycle 0: arbitration. Cycles 1–3: o_out_valid[3]=1, o_sel[3]=1, o_in_grant[1]=1.
  - Cycle 4: o_locked[3]=0.
- Contention with rr_ptr_2=0: inputs 0, 1, 4 each send a 1-flit packet to output 2, all requesting continuously.
  - Required grant order: 0, 1, 4, then 0 again.
  - Allocations occur every 2 cycles. rr_ptr_2 = 1, 2, 0 after each tail in turn (pointer wraps after input 4's tail).
- Back-pressure: locked packet in progress, i_out_ready[j]=0 for 3 cycles mid-packet.
  - o_out_valid[j]=0 and o_in_grant=0 during the stall; lock held; remaining flits resume with no loss.
- Independent outputs: input 0→out 1 and input 2→out 4 start in the same cycle.
  - Both lock next cycle and transfer in parallel, each gated by its own i_out_ready.
- Reset mid-packet: reset_n=0 for one cycle during flit 2 of 4.
  - Next cycle all o_locked=0, no grants; a fresh request re-arbitrates from rr_ptr=0.
- Invalid dest: i_dest[0]=6 with i_req[0]=1 for 10 cycles → no grant; other inputs unaffected.
